// File: rtl/clk_div_n.sv
// Programmable clock divider: divides clk_in by N (2..2^CNT_W-1) with 50% duty
// for both even and odd N, a period-start tick, glitch-free divisor reloads at
// period boundaries and a clean stop when the enable is withdrawn.
module clk_div_n #(
    parameter int CNT_W   = 8,
    parameter int RST_DIV = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_cur,
    output logic             load_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] r_div_cur;
    logic [CNT_W-1:0] w_div_cur_next;
    logic [CNT_W-1:0] r_pend_val;
    logic [CNT_W-1:0] w_pend_val_next;
    logic             r_pend_flag;
    logic             w_pend_flag_next;
    logic             r_pos_q;
    logic             w_pos_next;
    logic             r_neg_q;
    logic             r_tick;
    logic             w_tick_next;
    logic             r_load_err;
    logic             w_load_err_next;

    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_last;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_load_ok  = div_load && (div_val >= CNT_W'(2));
    assign w_load_bad = div_load && (div_val <  CNT_W'(2));
    assign w_last     = (r_cnt == (r_div_cur - CNT_W'(1)));
    // H = N/2 for even N and (N-1)/2 for odd N: both are N >> 1.
    assign w_half     = r_div_cur >> 1;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // Next-state, counter, half-cycle decode and divisor reload decisions.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_pos_next       = r_pos_q;
        w_tick_next      = 1'b0;
        w_div_cur_next   = r_div_cur;
        w_pend_val_next  = r_pend_val;
        w_pend_flag_next = r_pend_flag;
        w_load_err_next  = r_load_err | w_load_bad;

        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                w_pos_next = 1'b0;
                // No period in flight: a new divisor can take effect at once.
                if (w_load_ok) begin
                    w_div_cur_next   = div_val;
                    w_pend_flag_next = 1'b0;
                end else if (r_pend_flag) begin
                    w_div_cur_next   = r_pend_val;
                    w_pend_flag_next = 1'b0;
                end
                if (en) begin
                    w_state_next = ST_RUN;
                    w_pos_next   = 1'b1;
                    w_tick_next  = 1'b1;
                end
            end

            ST_RUN, ST_DRAIN: begin
                if (w_last) begin
                    // Period boundary: the previously pending divisor is adopted
                    // here; a load arriving on this same edge waits one period.
                    w_cnt_next = '0;
                    if (r_pend_flag) begin
                        w_div_cur_next   = r_pend_val;
                        w_pend_flag_next = 1'b0;
                    end
                    if (en) begin
                        w_state_next = ST_RUN;
                        w_pos_next   = 1'b1;
                        w_tick_next  = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_pos_next   = 1'b0;
                    end
                end else begin
                    // Mid-period: keep counting regardless of en so the
                    // period always completes at full length.
                    w_cnt_next   = w_cnt_inc;
                    w_pos_next   = (w_cnt_inc < w_half);
                    w_state_next = en ? ST_RUN : ST_DRAIN;
                end
                if (w_load_ok) begin
                    w_pend_val_next  = div_val;
                    w_pend_flag_next = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_pos_next   = 1'b0;
            end
        endcase
    end

    // Rising-edge state: FSM, counter, output phase, tick and divisor registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pos_q     <= 1'b0;
            r_tick      <= 1'b0;
            r_div_cur   <= CNT_W'(RST_DIV);
            r_pend_val  <= CNT_W'(RST_DIV);
            r_pend_flag <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_pos_q     <= w_pos_next;
            r_tick      <= w_tick_next;
            r_div_cur   <= w_div_cur_next;
            r_pend_val  <= w_pend_val_next;
            r_pend_flag <= w_pend_flag_next;
            r_load_err  <= w_load_err_next;
        end
    end

    // Falling-edge copy of the phase register, used to add the extra half
    // cycle of high time for odd divisors.
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
        end else begin
            r_neg_q <= r_pos_q;
        end
    end

    // Even N uses the rising-edge phase alone; odd N stretches it by half a cycle.
    assign clk_out  = r_pos_q | (r_div_cur[0] & r_neg_q);
    assign tick     = r_tick;
    assign div_cur  = r_div_cur;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_clk_div_n.sv
// Self-checking bench for clk_div_n. The reference model tracks only the
// period position and divisor; expected clk_out is derived from the rule that
// a period of N cycles is high for exactly its first N half-cycles.
module tb_clk_div_n;

    logic       clk_in;
    logic       rst_n;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       clk_out;
    logic       tick;
    logic [7:0] div_cur;
    logic       load_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_active;
    int m_k;
    int m_n;
    bit m_pend;
    int m_pend_v;
    bit m_err;

    // Per-cycle observed/expected: {tick, clk first half, clk second half, load_err, div_cur}
    logic [11:0] obs_vec;
    logic [11:0] exp_vec;

    clk_div_n #(.CNT_W(8), .RST_DIV(5)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_cur  (div_cur),
        .load_err (load_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        m_active = 0;
        m_k      = 0;
        m_n      = 5;
        m_pend   = 0;
        m_pend_v = 5;
        m_err    = 0;
    endtask

    // Drive one clk_in cycle, advance the model, sample both half-cycles.
    // Entered and left at falling edge + 1.
    task automatic drive_cycle(input logic e, input logic ld, input logic [7:0] v);
        logic s_tick, s_clk_a, s_err;
        logic [7:0] s_cur;
        logic x_tick, x_clk_a, x_clk_b;
        en       = e;
        div_load = ld;
        div_val  = v;
        @(posedge clk_in);
        if (ld && v < 2) m_err = 1;
        if (!m_active) begin
            if (ld && v >= 2) begin
                m_n = v; m_pend = 0;
            end else if (m_pend) begin
                m_n = m_pend_v; m_pend = 0;
            end
            if (e) begin
                m_active = 1; m_k = 0;
            end
        end else begin
            if (m_k == m_n - 1) begin
                if (m_pend) begin
                    m_n = m_pend_v; m_pend = 0;
                end
                m_k = 0;
                m_active = e;
            end else begin
                m_k++;
            end
            if (ld && v >= 2) begin
                m_pend_v = v; m_pend = 1;
            end
        end
        #1;
        s_tick  = tick;
        s_clk_a = clk_out;
        s_err   = load_err;
        s_cur   = div_cur;
        @(negedge clk_in);
        #1;
        x_tick  = m_active && (m_k == 0);
        x_clk_a = m_active && (2 * m_k < m_n);
        x_clk_b = m_active && (2 * m_k + 1 < m_n);
        obs_vec = {s_tick, s_clk_a, clk_out, s_err, s_cur};
        exp_vec = {x_tick, x_clk_a, x_clk_b, m_err, 8'(m_n)};
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = 8'd0;
        en       = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 0; div_load = 0; div_val = 0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++;
        if ({clk_out, tick, load_err} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_outputs: got clk_out/tick/load_err=%b want 000", {clk_out, tick, load_err});
        end
        n_checks++;
        if (div_cur !== 8'd5) begin
            n_errors++;
            $display("FAIL reset_div_cur: got %0d want 5", div_cur);
        end
        @(negedge clk_in); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 0, 0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL reset_idle: got %b want %b", obs_vec, exp_vec);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_default_n5();
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1, 0, 0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL default_n5 cyc%0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        $display("test_default_n5 done");
    endtask

    task automatic test_load_mid();
        for (int i = 0; i < 10 && m_k != 2; i++) drive_cycle(1, 0, 0);
        drive_cycle(1, 1, 8'd8);
        n_checks++;
        if (obs_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL load8_at_cnt2: got %b want %b", obs_vec, exp_vec);
        end
        for (int i = 0; i < 22; i++) begin
            drive_cycle(1, 0, 0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL load8_run cyc%0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        $display("test_load_mid done");
    endtask

    task automatic test_bad_load();
        drive_cycle(1, 1, 8'd1);
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1, 0, 0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL bad_load1 cyc%0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        drive_cycle(1, 1, 8'd2);
        for (int i = 0; i < 14; i++) begin
            drive_cycle(1, 0, 0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL load2_run cyc%0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        $display("test_bad_load done");
    endtask

    task automatic test_en_drop();
        drive_cycle(1, 1, 8'd7);
        for (int i = 0; i < 40 && !(m_n == 7 && m_k == 1); i++) drive_cycle(1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive_cycle(0, 0, 0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL en_drop_n7 cyc%0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        $display("test_en_drop done");
    endtask

    task automatic test_back_to_back();
        drive_cycle(1, 0, 0);
        for (int i = 0; i < 10 && m_k != 2; i++) drive_cycle(1, 0, 0);
        drive_cycle(1, 1, 8'd9);
        for (int i = 0; i < 10 && m_k != m_n - 1; i++) drive_cycle(1, 0, 0);
        drive_cycle(1, 1, 8'd4);
        for (int i = 0; i < 24; i++) begin
            drive_cycle(1, 0, 0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL back_to_back cyc%0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_midhigh();
        for (int i = 0; i < 20 && m_active; i++) drive_cycle(0, 0, 0);
        drive_cycle(0, 1, 8'd255);
        for (int i = 0; i < 60 && m_k != 50; i++) begin
            drive_cycle(1, 0, 0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL n255_run cyc%0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (clk_out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_midhigh_clk: got %b want 0", clk_out);
        end
        model_reset();
        @(negedge clk_in); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 0, 0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL after_reset_idle cyc%0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 11; i++) begin
            drive_cycle(1, 0, 0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL after_reset_run cyc%0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        $display("test_reset_midhigh done");
    endtask

    task automatic test_random();
        logic e;
        logic ld;
        logic [7:0] v;
        e = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) e = ~e;
            ld = ($urandom_range(0, 9) == 0);
            v  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(2, 13));
            drive_cycle(e, ld, v);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL random cyc%0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_default_n5();
        test_load_mid();
        test_bad_load();
        test_en_drop();
        test_back_to_back();
        test_reset_midhigh();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
